// File: rtl/pipe_em_stage.sv
// ---------------------------------------------------------------------------
// pipe_em_stage
//   EXE/MEM pipeline stage register with valid/ready flow control,
//   synchronous flush and an optional second (skid) entry.
//
//   Build option: define PIPE_EM_SKID_EN for the two-entry skid buffer
//   (e_ready registered, no path from m_ready). Without it the stage holds a
//   single entry and e_ready = !m_valid || m_ready.
//
// Ports
//   clock, resetn       rising-edge clock, asynchronous active-low reset
//   flush               synchronous flush, drops held entries and same-cycle in/out
//   e_valid/e_ready     EXE-side handshake
//   ectrl/ealu/eb/ern   EXE entry (control bits, ALU result, store data, dest reg)
//   m_valid/m_ready     MEM-side handshake
//   mctrl/malu/mb/mrn   MEM entry; mctrl forced to zero when m_valid=0
//   occ                 number of held entries (0..2)
// ---------------------------------------------------------------------------
module pipe_em_stage #(
    parameter int DATA_W = 32,
    parameter int RN_W   = 5,
    parameter int CTRL_W = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              e_valid,
    output logic              e_ready,
    input  logic [CTRL_W-1:0] ectrl,
    input  logic [DATA_W-1:0] ealu,
    input  logic [DATA_W-1:0] eb,
    input  logic [RN_W-1:0]   ern,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CTRL_W-1:0] mctrl,
    output logic [DATA_W-1:0] malu,
    output logic [DATA_W-1:0] mb,
    output logic [RN_W-1:0]   mrn,
    output logic [1:0]        occ
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] b;
        logic [RN_W-1:0]   rn;
    } entry_t;

    state_t state, state_nx;
    entry_t main_q, skid_q, in_entry;

    logic in_fire, out_fire;
    logic load_main_in, load_main_skid, load_skid_in;

    assign in_entry = '{ctrl: ectrl, alu: ealu, b: eb, rn: ern};

    assign m_valid  = (state != EMPTY);
    assign occ      = state;

`ifdef PIPE_EM_SKID_EN
    // Ready depends on state only, so MEM stalls never ripple back into EXE
    // within the same cycle.
    assign e_ready  = (state != FULL);
`else
    assign e_ready  = !m_valid || m_ready;
`endif

    assign in_fire  = e_valid && e_ready;
    assign out_fire = m_valid && m_ready;

    // Bubbles must never carry wreg/m2reg/wmem into MEM.
    assign mctrl    = m_valid ? main_q.ctrl : '0;
    assign malu     = main_q.alu;
    assign mb       = main_q.b;
    assign mrn      = main_q.rn;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            // Flush wins over everything: the same-cycle input and output are
            // both dropped, and data registers keep their last value.
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nx     = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (out_fire) begin
                        state_nx = EMPTY;
`ifdef PIPE_EM_SKID_EN
                    end else if (in_fire) begin
                        state_nx     = FULL;
                        load_skid_in = 1'b1;
`endif
                    end
                end
                FULL: begin
                    // The older skid entry moves forward before any new entry
                    // is accepted; e_ready is low in this state.
                    if (out_fire) begin
                        state_nx       = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_entry;
            end
        end
    end

endmodule

// File: doc/pipe_em_stage.md
# pipe_em_stage

Parametrised EXE/MEM pipeline stage register with valid/ready flow control, synchronous flush and a two-entry skid buffer. It carries the EXE-stage result (ALU value, store data, destination register number, control bits) into the MEM stage. Unlike a plain edge-triggered latch, it supports back-pressure from MEM stalls and bubble insertion on branch/exception flush. Control bits reaching MEM are forced to zero whenever no valid entry is presented, so a bubble can never write the register file or memory.

## Interface
- DATA_W, 32: width of alu and b data fields
- RN_W, 5: width of destination register number
- CTRL_W, 3: control bit count; bit0=wreg, bit1=m2reg, bit2=wmem, upper bits user-defined
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- flush  in  1  synchronous flush; discards all held entries and any same-cycle input
- e_valid  in  1  EXE presents a valid entry
- e_ready  out  1  stage can accept an entry this cycle
- ectrl  in  CTRL_W  EXE control bits
- ealu  in  DATA_W  EXE ALU result
- eb  in  DATA_W  EXE store data
- ern  in  RN_W  EXE destination register
- m_valid  out  1  MEM-side entry valid
- m_ready  in  1  MEM consumes entry this cycle
- mctrl  out  CTRL_W  control bits; all-zero when m_valid=0
- malu  out  DATA_W  ALU result
- mb  out  DATA_W  store data
- mrn  out  RN_W  destination register
- occ  out  2  occupancy, 0..2

## Operation
- Transfer-in when e_valid && e_ready; transfer-out when m_valid && m_ready.
- Storage: main entry drives the m_* outputs, and a skid entry sits behind it. States: EMPTY (occ=0), ONE (occ=1), FULL (occ=2).
- EMPTY: in -> ONE, with the entry loaded into main.
- ONE: in only -> FULL, with the entry loaded into skid.
- ONE: out only -> EMPTY.
- ONE: in and out together -> ONE, with main reloaded from the input.
- FULL: e_ready=0. Out -> ONE, with skid moved to main. The skid entry goes out before any newer entry.
- FULL: no out -> stay FULL.
- Entries leave in the order they arrived; none is lost or duplicated.
- m_valid = (occ != 0). mctrl = main.ctrl when m_valid, else zero.
- malu/mb/mrn hold their last value when empty. They are stable while m_valid && !m_ready.
- flush: next state EMPTY and occ=0. Any same-cycle input is discarded, and so is any same-cycle out. flush has priority over every other event.
- Reset: occ=0, m_valid=0, mctrl=0, malu=0, mb=0, mrn=0, skid contents=0.

## Timing
- Latency: 1 cycle from transfer-in to m_valid, when the stage was EMPTY, or ONE with a same-cycle out.
- Throughput: 1 entry per cycle while m_ready=1.
- e_ready (skid enabled) is registered: e_ready = (occ != 2), evaluated from state only.
- After a FULL-state out, e_ready rises on the following cycle.
- Reset asserts outputs immediately, with no clock needed. On release, the first transfer-in can occur on the first rising edge.
- Reset asserted mid-stall drops all entries.
- flush takes effect at the edge it is sampled. The cycle after it: m_valid=0, mctrl=0, e_ready=1.

## Configuration
- PIPE_EM_SKID_EN defined: two-entry skid as described, and e_ready has no combinational path from m_ready.
- PIPE_EM_SKID_EN undefined: single entry only, and occ never exceeds 1. e_ready = !m_valid || m_ready, which is combinational from m_ready. The FULL state does not exist.
- Flush, bubble zeroing and reset behaviour are identical in both builds.

## Test plan
- Reset with inputs ealu=32'hDEADBEEF, ectrl=3'b111 and e_valid=1 held -> m_valid=0, mctrl=0, malu=0 during reset. After release, malu=32'hDEADBEEF and mctrl=3'b111 one cycle later.
- Stream of 8 entries (ealu=1..8) with m_ready=1 -> m_valid high for 8 consecutive cycles and malu=1..8 in order.
- m_ready=0 while pushing A=0x10 then B=0x20 -> occ=2 and e_ready=0. Raise m_ready -> A then B emerge with no loss, and e_ready returns the cycle after A leaves.
- FULL with flush=1 and e_valid=1 (ealu=0x30) -> next cycle occ=0, m_valid=0 and mctrl=0. 0x30 never appears.
- ectrl=3'b101 with e_valid=0 -> mctrl stays 0 (bubble cannot assert wreg/wmem).
- Skid disabled: m_ready=0 with an entry held -> e_ready=0. Same cycle, raise m_ready=1 -> e_ready=1 combinationally, and the new entry is accepted on that edge.
